operand_fetch_stage: RTL and testbench

//  RV32IM operand-fetch stage feeding the combinational 32-bit ALU.

---
 rtl/rv32_pkg.sv | 25 ++
 rtl/regfile_2r1w.sv | 48 ++++
 rtl/operand_fetch_stage.sv | 120 ++++++++++++
 tb/tb_operand_fetch_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 field positions, opcode constants and small decode helpers used
// by the operand-fetch stage and its register file.
package rv32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;
    localparam int RD_LSB     = 7;

    localparam logic [6:0] OP_R  = 7'h33;
    localparam logic [6:0] OP_I  = 7'h13;
    localparam logic [6:0] OP_LD = 7'h03;
    localparam logic [6:0] OP_ST = 7'h23;
    localparam logic [6:0] OP_BR = 7'h63;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // A writeback only forwards when it targets a real register.
    function automatic logic wb_hits(input logic      wb_en,
                                     input reg_addr_t wb_rd,
                                     input reg_addr_t rs);
        return wb_en && (wb_rd != '0) && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Integer register file: two asynchronous read ports, one synchronous write
// port, x0 reads as zero and ignores writes.
module regfile_2r1w
    import rv32_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]      rdata1,
    output logic [WIDTH-1:0]      rdata2
);

    logic [WIDTH-1:0] regs_q [NUM_REGS];

    // Per-entry flops so every register clears on reset; entry 0 never loads.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        regs_q[gi] <= '0;
                    end else begin
                        regs_q[gi] <= '0;
                    end
                end
            end else begin : g_rw
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        regs_q[gi] <= '0;
                    end else if (we && (waddr == REG_ADDR_W'(gi))) begin
                        regs_q[gi] <= wdata;
                    end
                end
            end
        end
    endgenerate

    assign rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];

endmodule

// File: rtl/operand_fetch_stage.sv
// RV32IM operand fetch: register-file read with writeback bypass, feeding a
// one-entry valid/ready output buffer that drives the ALU.
module operand_fetch_stage
    import rv32_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 32,
    parameter int PC_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_inst,
    input  logic [PC_W-1:0]       in_pc,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [WIDTH-1:0]      wb_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_a,
    output logic [WIDTH-1:0]      out_b,
    output logic [WIDTH-1:0]      out_inst,
    output logic [PC_W-1:0]       out_pc
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_a_q, out_a_d;
    logic [WIDTH-1:0] out_b_q, out_b_d;
    logic [WIDTH-1:0] out_inst_q, out_inst_d;
    logic [PC_W-1:0]  out_pc_q, out_pc_d;

    reg_addr_t        rs1, rs2, buf_rs1, buf_rs2;
    logic [WIDTH-1:0] rf_rdata1, rf_rdata2;
    logic [WIDTH-1:0] op_a, op_b;
    logic             capture, stall;

    assign rs1     = in_inst[RS1_LSB +: REG_ADDR_W];
    assign rs2     = in_inst[RS2_LSB +: REG_ADDR_W];
    assign buf_rs1 = out_inst_q[RS1_LSB +: REG_ADDR_W];
    assign buf_rs2 = out_inst_q[RS2_LSB +: REG_ADDR_W];

    regfile_2r1w #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wb_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // Same-cycle writeback beats the file, which only commits at this edge.
    assign op_a = wb_hits(wb_en, wb_rd, rs1) ? wb_data : rf_rdata1;
    assign op_b = wb_hits(wb_en, wb_rd, rs2) ? wb_data : rf_rdata2;

    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign stall    = out_valid_q && !out_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
            out_a_d     = op_a;
            out_b_d     = op_b;
            out_inst_d  = in_inst;
            out_pc_d    = in_pc;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // A held instruction would otherwise carry operands that went stale
        // while it waited for execute.
        if (stall && !flush) begin
            if (wb_hits(wb_en, wb_rd, buf_rs1)) begin
                out_a_d = wb_data;
            end
            if (wb_hits(wb_en, wb_rd, buf_rs2)) begin
                out_b_d = wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage: a per-cycle vector table followed by
// hand-written reset sequences.
module tb_operand_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int tests_run = 0;
    int tests_failed = 0;

    operand_fetch_stage #(
        .WIDTH    (32),
        .NUM_REGS (32),
        .PC_W     (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_inst  (out_inst),
        .out_pc    (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic        flush;
        logic        out_ready;
        logic        e_in_ready;
        logic        e_valid;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    function automatic vec_t mkv(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                                 input logic we, input logic [4:0] rd, input logic [31:0] wd,
                                 input logic fl, input logic ordy, input logic e_ir,
                                 input logic e_v, input logic [31:0] e_a, input logic [31:0] e_b,
                                 input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.in_valid = iv;  v.inst = inst;   v.pc = pc;
        v.wb_en = we;     v.wb_rd = rd;    v.wb_data = wd;
        v.flush = fl;     v.out_ready = ordy;
        v.e_in_ready = e_ir; v.e_valid = e_v;
        v.e_a = e_a; v.e_b = e_b; v.e_inst = e_inst; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        in_valid = 1'b0; in_inst = '0; in_pc = '0;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0; out_ready = 1'b1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        @(negedge clk);
        in_valid = v.in_valid; in_inst = v.inst; in_pc = v.pc;
        wb_en = v.wb_en; wb_rd = v.wb_rd; wb_data = v.wb_data;
        flush = v.flush; out_ready = v.out_ready;
        #1;
        chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.e_in_ready));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", idx), 32'(out_valid), 32'(v.e_valid));
        chk($sformatf("v%0d out_a", idx), out_a, v.e_a);
        chk($sformatf("v%0d out_b", idx), out_b, v.e_b);
        chk($sformatf("v%0d out_inst", idx), out_inst, v.e_inst);
        chk($sformatf("v%0d out_pc", idx), out_pc, v.e_pc);
        $display("[TB] vec %0d iv=%0b rdy=%0b fl=%0b -> ov=%0b a=%08h b=%08h pc=%08h",
                 idx, v.in_valid, v.out_ready, v.flush, out_valid, out_a, out_b, out_pc);
    endtask

    vec_t vecs[18];

    initial begin
        logic [31:0] i1, i2, i3, i4, i5, i6, i7, i8, i9;
        i1 = r_type(7'h00, 5'd0,  5'd5, 5'd1);   // add x1,x5,x0
        i2 = r_type(7'h20, 5'd7,  5'd7, 5'd2);   // sub x2,x7,x7
        i3 = r_type(7'h00, 5'd7,  5'd0, 5'd3);   // add x3,x0,x7
        i4 = r_type(7'h00, 5'd7,  5'd5, 5'd4);   // add x4,x5,x7
        i5 = r_type(7'h00, 5'd5,  5'd7, 5'd6);   // add x6,x7,x5
        i6 = r_type(7'h20, 5'd5,  5'd5, 5'd9);   // sub x9,x5,x5
        i7 = r_type(7'h00, 5'd0,  5'd7, 5'd10);  // add x10,x7,x0
        i8 = r_type(7'h00, 5'd1,  5'd1, 5'd11);  // add x11,x1,x1
        i9 = r_type(7'h00, 5'd31, 5'd1, 5'd12);  // add x12,x1,x31

        //             iv inst pc      we rd     wdata         fl rdy  eir ev a             b             inst pc
        vecs[0]  = mkv(0, 0,  32'h0,   1, 5'd5,  32'hDEADBEEF, 0, 1,   1,  0, 32'h0,        32'h0,        0,  32'h0);
        vecs[1]  = mkv(1, i1, 32'h100, 0, 5'd0,  32'h0,        0, 1,   1,  1, 32'hDEADBEEF, 32'h0,        i1, 32'h100);
        vecs[2]  = mkv(1, i2, 32'h104, 1, 5'd7,  32'h12345678, 0, 1,   1,  1, 32'h12345678, 32'h12345678, i2, 32'h104);
        vecs[3]  = mkv(1, i3, 32'h108, 1, 5'd0,  32'hFFFFFFFF, 0, 1,   1,  1, 32'h0,        32'h12345678, i3, 32'h108);
        vecs[4]  = mkv(0, 0,  32'h0,   0, 5'd0,  32'h0,        0, 1,   1,  0, 32'h0,        32'h12345678, i3, 32'h108);
        vecs[5]  = mkv(1, i4, 32'h10C, 0, 5'd0,  32'h0,        0, 0,   1,  1, 32'hDEADBEEF, 32'h12345678, i4, 32'h10C);
        vecs[6]  = mkv(1, i5, 32'h110, 0, 5'd0,  32'h0,        0, 0,   0,  1, 32'hDEADBEEF, 32'h12345678, i4, 32'h10C);
        vecs[7]  = mkv(1, i5, 32'h110, 1, 5'd5,  32'h55,       0, 0,   0,  1, 32'h55,       32'h12345678, i4, 32'h10C);
        vecs[8]  = mkv(1, i5, 32'h110, 1, 5'd7,  32'h77,       0, 0,   0,  1, 32'h55,       32'h77,       i4, 32'h10C);
        vecs[9]  = mkv(1, i5, 32'h110, 0, 5'd0,  32'h0,        0, 1,   1,  1, 32'h77,       32'h55,       i5, 32'h110);
        vecs[10] = mkv(1, i6, 32'h114, 0, 5'd0,  32'h0,        0, 1,   1,  1, 32'h55,       32'h55,       i6, 32'h114);
        vecs[11] = mkv(1, i7, 32'h118, 0, 5'd0,  32'h0,        1, 0,   0,  0, 32'h55,       32'h55,       i6, 32'h114);
        vecs[12] = mkv(1, i7, 32'h118, 0, 5'd0,  32'h0,        1, 0,   1,  0, 32'h55,       32'h55,       i6, 32'h114);
        vecs[13] = mkv(1, i7, 32'h118, 0, 5'd0,  32'h0,        0, 0,   1,  1, 32'h77,       32'h0,        i7, 32'h118);
        vecs[14] = mkv(1, i8, 32'h11C, 1, 5'd1,  32'hA5A5A5A5, 0, 1,   1,  1, 32'hA5A5A5A5, 32'hA5A5A5A5, i8, 32'h11C);
        vecs[15] = mkv(1, i9, 32'h120, 0, 5'd31, 32'h0,        0, 1,   1,  1, 32'hA5A5A5A5, 32'h0,        i9, 32'h120);
        vecs[16] = mkv(0, 0,  32'h0,   1, 5'd31, 32'h31,       0, 0,   0,  1, 32'hA5A5A5A5, 32'h31,       i9, 32'h120);
        vecs[17] = mkv(0, 0,  32'h0,   0, 5'd0,  32'h0,        0, 1,   1,  0, 32'hA5A5A5A5, 32'h31,       i9, 32'h120);

        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'h0);
        chk("reset out_a", out_a, 32'h0);
        chk("reset out_pc", out_pc, 32'h0);
        chk("reset in_ready", 32'(in_ready), 32'h1);

        for (int i = 0; i < 18; i++) begin
            apply(i, vecs[i]);
        end

        // Async reset while an instruction is buffered and stalled.
        @(negedge clk);
        in_valid = 1'b1; in_inst = i4; in_pc = 32'h200; out_ready = 1'b0;
        wb_en = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-reset out_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", 32'(out_valid), 32'h0);
        chk("async reset out_a", out_a, 32'h0);
        chk("async reset out_b", out_b, 32'h0);
        chk("async reset out_inst", out_inst, 32'h0);
        chk("async reset out_pc", out_pc, 32'h0);
        $display("[TB] async reset mid-stall: ov=%0b a=%08h", out_valid, out_a);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;

        // Every register must read back zero after reset.
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_inst = r_type(7'h00, 5'(32 - r), 5'(r), 5'd1);
            in_pc = 32'(r);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("post-reset x%0d out_a", r), out_a, 32'h0);
            chk($sformatf("post-reset x%0d out_b", 32 - r), out_b, 32'h0);
            chk($sformatf("post-reset x%0d out_valid", r), 32'(out_valid), 32'h1);
            $display("[TB] read x%0d/x%0d after reset: a=%08h b=%08h", r, 32 - r, out_a, out_b);
        end

        @(negedge clk);
        drive_idle();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
